oloca_err_monitor: RTL and testbench
====================================

Name: oloca_err_monitor

Overview:
Checker-side companion to the OLOCA approximate adder. It consumes stimulus/result pairs (a, b, approx_sum) over a valid/ready stream and recomputes the exact sum. Over a window of 2^WIN_LOG2 samples it accumulates error statistics: error count, sum of error distance (SED) and maximum error distance. It sits after the adder in characterisation and self-test datapaths and reports one result record per window.

Parameters:
WIN_LOG2, 8, log2 of samples per window (1..16)
DATA_W, 8, operand width; approx_sum and exact sum are DATA_W+1 bits
SED_W, DATA_W+1+WIN_LOG2, derived (localparam), SED accumulator width; must never overflow

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse: begin a new window (honoured only in IDLE)
in_valid  input  1  sample valid
in_ready  output  1  sample accepted when in_valid & in_ready
a  input  DATA_W  operand A as fed to the adder
b  input  DATA_W  operand B as fed to the adder
approx_sum  input  DATA_W+1  adder output under test
res_valid  output  1  window result available, held until taken
res_ready  input  1  result consumed when res_valid & res_ready
err_count  output  WIN_LOG2+1  samples with approx_sum != exact
sed  output  SED_W  sum of |exact - approx_sum|
max_ed  output  DATA_W+1  largest single error distance in window
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready, res_valid and busy =0; err_count, sed and max_ed =0; sample counter and pipeline register cleared. Reset mid-window discards partial results with no report.
- FSM states IDLE, ACCUM, FLUSH, REPORT.
- IDLE: in_ready=0. start=1 -> ACCUM. Entering ACCUM clears the accumulators and sample counter.
- ACCUM: in_ready=1. Each accept computes exact = a+b at DATA_W+1 bits (zero-extended, no truncation) and ed = |exact - approx_sum|, registered in stage 1 with a valid flag.
  - Stage 2, one cycle later: if ed!=0, err_count+=1. sed+=ed (zero-extended). max_ed=max(max_ed,ed).
  - Total latency from accept to accumulator update: 2 edges.
  - On the 2^WIN_LOG2-th accept, the same cycle drives in_ready=0 next cycle and transitions to FLUSH.
- FLUSH: one cycle; in_ready=0; the final stage-1 sample is accumulated -> REPORT.
- REPORT: res_valid=1; err_count, sed and max_ed are stable and held. On res_valid & res_ready -> IDLE, res_valid=0 next cycle.
  - If start=1 in the handshake cycle -> ACCUM directly, accumulators cleared; the reported values are not visible after that edge.
- start outside IDLE/REPORT-handshake is ignored.
- in_valid gaps in ACCUM are allowed; the counter advances only on accepts.
- Output register values persist in IDLE until the next window start clears them.
- Boundaries:
  - ed=0 still counts as a sample.
  - Full-window worst case (every ed = 2^(DATA_W+1)-1) fits SED_W exactly.
  - err_count may equal 2^WIN_LOG2.

Optional Feature:
OLOCA_BIAS_EN: when defined, adds output port err_bias (signed, SED_W+1 bits) accumulating signed (exact - approx_sum) per sample in stage 2. It is cleared and held exactly like sed. When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIN_LOG2=2. Reset, start. Samples (0x0F,0x01,0x00F), (0x0F,0x0F,0x00F), (0xFF,0xFF,0x1EF), (0x10,0x20,0x030) -> res_valid 2 cycles after 4th accept; err_count=3, sed=31, max_ed=15; err_bias=+31 if OLOCA_BIAS_EN.
- Same window with in_valid toggled every other cycle -> identical results; in_ready stays 1 until 4th accept.
- All samples exact (approx_sum=a+b) -> err_count=0, sed=0, max_ed=0.
- Hold res_ready=0 for 10 cycles in REPORT -> res_valid and outputs stable, in_ready=0, extra in_valid ignored.
- rst_n low after 2 accepts, then start and a fresh 4-sample window -> results reflect only the new 4 samples.
- res_ready=1 and start=1 in the same cycle -> immediate ACCUM, in_ready=1 next cycle, accumulators zeroed.

Source files
------------

// File: rtl/oloca_err_monitor.sv
// Error-statistics monitor for the OLOCA approximate adder: per window of 2^WIN_LOG2
// samples reports error count, sum of error distance and max error distance.
// Optional signed error-bias accumulator enabled by defining OLOCA_BIAS_EN.
module oloca_err_monitor #(
    parameter int WIN_LOG2 = 8,
    parameter int DATA_W   = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_W-1:0]                 a,
    input  logic [DATA_W-1:0]                 b,
    input  logic [DATA_W:0]                   approx_sum,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [WIN_LOG2:0]                 err_count,
    output logic [DATA_W+WIN_LOG2:0]          sed,
    output logic [DATA_W:0]                   max_ed,
`ifdef OLOCA_BIAS_EN
    output logic signed [DATA_W+WIN_LOG2+1:0] err_bias,
`endif
    output logic                              busy
);

    localparam int SED_W = DATA_W + 1 + WIN_LOG2;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid is held by the producer until it is taken, ready never depends on valid.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_FLUSH  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIN_LOG2-1:0] smp_cnt;
    logic                accept;
    logic                last_accept;
    logic                res_take;
    logic                win_clear;
    logic [DATA_W:0]     exact;
    logic [DATA_W:0]     ed_now;
    logic                s1_valid;
    logic [DATA_W:0]     s1_ed;
`ifdef OLOCA_BIAS_EN
    logic signed [DATA_W+1:0] diff_now;
    logic signed [DATA_W+1:0] s1_diff;
`endif

    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (smp_cnt == '1);
    assign res_take    = res_valid && res_ready;
    // A new window starts from IDLE, or directly out of the result handshake.
    assign win_clear   = ((state == S_IDLE) && start) || (res_take && start);

    // Exact sum kept at full DATA_W+1 width so the carry is never lost.
    assign exact  = {1'b0, a} + {1'b0, b};
    assign ed_now = (exact >= approx_sum) ? (exact - approx_sum) : (approx_sum - exact);
`ifdef OLOCA_BIAS_EN
    assign diff_now = $signed({1'b0, exact}) - $signed({1'b0, approx_sum});
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_ACCUM;
            S_ACCUM:  if (last_accept) state_nxt = S_FLUSH;
            S_FLUSH:  state_nxt = S_REPORT;
            S_REPORT: if (res_take) state_nxt = start ? S_ACCUM : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE:   busy      = 1'b0;
            S_ACCUM:  in_ready  = 1'b1;
            S_REPORT: res_valid = 1'b1;
            default:  ;
        endcase
    end

    // Sample counter: advances only on accepts, wraps to zero on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt <= '0;
        end else if (win_clear) begin
            smp_cnt <= '0;
        end else if (accept) begin
            smp_cnt <= smp_cnt + WIN_LOG2'(1);
        end
    end

    // Stage 1: register the per-sample error distance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ed    <= '0;
        end else begin
            s1_valid <= accept && !win_clear;
            if (accept) begin
                s1_ed <= ed_now;
            end
        end
    end

`ifdef OLOCA_BIAS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_diff <= '0;
        end else if (accept) begin
            s1_diff <= diff_now;
        end
    end
`endif

    // Stage 2: accumulate; the registers double as the held result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            sed       <= '0;
            max_ed    <= '0;
        end else if (win_clear) begin
            err_count <= '0;
            sed       <= '0;
            max_ed    <= '0;
        end else if (s1_valid) begin
            if (s1_ed != '0) begin
                err_count <= err_count + (WIN_LOG2+1)'(1);
            end
            sed <= sed + SED_W'(s1_ed);
            if (s1_ed > max_ed) begin
                max_ed <= s1_ed;
            end
        end
    end

`ifdef OLOCA_BIAS_EN
    // Signed bias is sign-extended into the accumulator width before adding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_bias <= '0;
        end else if (win_clear) begin
            err_bias <= '0;
        end else if (s1_valid) begin
            err_bias <= err_bias + (SED_W+1)'(s1_diff);
        end
    end
`endif

endmodule

// File: tb/tb_oloca_err_monitor.sv
// Directed bench for oloca_err_monitor with a 4-sample window (WIN_LOG2=2, DATA_W=8).
// Expected window results are hand-computed and queued before each window is driven.
module tb_oloca_err_monitor;

  localparam int WIN_LOG2 = 2;
  localparam int DATA_W   = 8;
  localparam int RW       = 3 + 11 + 9;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [7:0]          a;
  logic [7:0]          b;
  logic [8:0]          approx_sum;
  logic                res_valid;
  logic                res_ready;
  logic [2:0]          err_count;
  logic [10:0]         sed;
  logic [8:0]          max_ed;
`ifdef OLOCA_BIAS_EN
  logic signed [11:0]  err_bias;
`endif
  logic                busy;

  int vectors;
  int miscompares;

  logic [RW-1:0] exp_q[$];
  int            exp_bias_q[$];

  oloca_err_monitor #(.WIN_LOG2(WIN_LOG2), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .approx_sum (approx_sum),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .err_count  (err_count),
    .sed        (sed),
    .max_ed     (max_ed),
`ifdef OLOCA_BIAS_EN
    .err_bias   (err_bias),
`endif
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [8:0] sv);
    int t;
    t = 0;
    a = av;
    b = bv;
    approx_sum = sv;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_report(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!res_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(res_valid), 32'd1);
  endtask

  task automatic take_result();
    @(negedge clk);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // scoreboard
  task automatic push_exp(input logic [2:0] ec, input logic [10:0] sd, input logic [8:0] mx,
                          input int bias);
    exp_q.push_back({ec, sd, mx});
    exp_bias_q.push_back(bias);
  endtask

  task automatic check_result(input string tag);
    logic [RW-1:0] e;
    int            eb;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
      return;
    end
    e  = exp_q.pop_front();
    eb = exp_bias_q.pop_front();
    check({tag, "_err_count"}, 32'(err_count), 32'(e[22:20]));
    check({tag, "_sed"},       32'(sed),       32'(e[19:9]));
    check({tag, "_max_ed"},    32'(max_ed),    32'(e[8:0]));
`ifdef OLOCA_BIAS_EN
    check({tag, "_err_bias"},  32'(err_bias),  32'(eb));
`else
    if (eb > 100000) check({tag, "_bias_range"}, 32'(eb), 32'd0);
`endif
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b0;
    a = '0;
    b = '0;
    approx_sum = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_sed",       32'(sed),       32'd0);
    check("rst_max_ed",    32'(max_ed),    32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // window 1: mixed errors, back-to-back samples, exact latency
    pulse_start();
    check("w1_in_ready", 32'(in_ready), 32'd1);
    check("w1_busy",     32'(busy),     32'd1);
    push_exp(3'd3, 11'd31, 9'd15, 31);
    send(8'h0F, 8'h01, 9'h00F);
    send(8'h0F, 8'h0F, 9'h00F);
    send(8'hFF, 8'hFF, 9'h1EF);
    send(8'h10, 8'h20, 9'h030);
    @(negedge clk);
    check("w1_flush_in_ready",  32'(in_ready),  32'd0);
    check("w1_flush_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("w1_res_valid_lat2", 32'(res_valid), 32'd1);
    check_result("w1");
    take_result();
    check("w1_done_res_valid", 32'(res_valid), 32'd0);
    check("w1_done_busy",      32'(busy),      32'd0);
    check("w1_idle_persist",   32'(sed),       32'd31);

    // window 2: same samples with in_valid gaps and an ignored start mid-window
    pulse_start();
    check("w2_cleared", 32'(sed), 32'd0);
    push_exp(3'd3, 11'd31, 9'd15, 31);
    send(8'h0F, 8'h01, 9'h00F);
    tick();
    check("w2_gap1_ready", 32'(in_ready), 32'd1);
    send(8'h0F, 8'h0F, 9'h00F);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("w2_gap2_ready", 32'(in_ready), 32'd1);
    send(8'hFF, 8'hFF, 9'h1EF);
    tick();
    check("w2_gap3_ready", 32'(in_ready), 32'd1);
    send(8'h10, 8'h20, 9'h030);
    wait_report("w2_report");
    check_result("w2");
    take_result();

    // window 3: all samples exact
    pulse_start();
    push_exp(3'd0, 11'd0, 9'd0, 0);
    send(8'h01, 8'h02, 9'h003);
    send(8'h80, 8'h80, 9'h100);
    send(8'hFF, 8'hFF, 9'h1FE);
    send(8'h00, 8'h00, 9'h000);
    wait_report("w3_report");
    check_result("w3");
    take_result();

    // window 4: worst-case error every sample, result held for 10 cycles
    pulse_start();
    push_exp(3'd4, 11'd2044, 9'd511, -2044);
    repeat (4) send(8'h00, 8'h00, 9'h1FF);
    wait_report("w4_report");
    in_valid = 1'b1;
    a = 8'h55;
    b = 8'h55;
    approx_sum = 9'h000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("w4_hold_res_valid", 32'(res_valid), 32'd1);
      check("w4_hold_in_ready",  32'(in_ready),  32'd0);
      check("w4_hold_sed",       32'(sed),       32'd2044);
    end
    in_valid = 1'b0;
    check_result("w4");
    take_result();

    // reset mid-window discards the partial window
    pulse_start();
    send(8'hFF, 8'hFF, 9'h000);
    send(8'hFF, 8'hFF, 9'h000);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_sed",       32'(sed),       32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("mid_rst_no_report", 32'(res_valid), 32'd0);
    pulse_start();
    push_exp(3'd3, 11'd31, 9'd15, 31);
    send(8'h0F, 8'h01, 9'h00F);
    send(8'h0F, 8'h0F, 9'h00F);
    send(8'hFF, 8'hFF, 9'h1EF);
    send(8'h10, 8'h20, 9'h030);
    wait_report("w5_report");
    check_result("w5");

    // result handshake with start in the same cycle goes straight to ACCUM
    @(negedge clk);
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    res_ready = 1'b0;
    start = 1'b0;
    check("bb_in_ready",  32'(in_ready),  32'd1);
    check("bb_res_valid", 32'(res_valid), 32'd0);
    check("bb_err_count", 32'(err_count), 32'd0);
    check("bb_sed",       32'(sed),       32'd0);
    check("bb_max_ed",    32'(max_ed),    32'd0);
    push_exp(3'd3, 11'd22, 9'd16, 20);
    send(8'h01, 8'h01, 9'h003);
    send(8'h02, 8'h02, 9'h004);
    send(8'h0A, 8'h05, 9'h00A);
    send(8'h80, 8'h80, 9'h0F0);
    wait_report("w6_report");
    check_result("w6");
    take_result();
    check("w6_idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
